// File: rtl/nic_pkg.sv
// Shared definitions for the Cardinal NIC: CPU register map, packet layout and status word packing.
package nic_pkg;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Bit indices use the ring's big-endian numbering: bit 0 is the MSB of a [0:63] word.
  localparam int PKT_VC_BIT  = 0;
  localparam int PKT_DIR_BIT = 1;
  localparam int PKT_HOP_LO  = 8;
  localparam int PKT_HOP_HI  = 15;
  localparam int PKT_SRC_LO  = 16;
  localparam int PKT_SRC_HI  = 31;
  localparam int PKT_PAY_LO  = 32;
  localparam int PKT_PAY_HI  = 63;

  typedef struct packed {
    logic        vc;
    logic        dir;
    logic [5:0]  rsvd;
    logic [7:0]  hops;
    logic [15:0] src;
    logic [31:0] payload;
  } pkt_t;

  // Status word: occupancy in bits 56:62, flag in bit 63, everything else zero.
  function automatic logic [0:63] nic_status(input logic flag, input logic [6:0] occ);
    return {56'h0, occ, flag};
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// Circular packet FIFO: head is visible combinationally, push and pop each take effect at the edge.
// A push while full is accepted only when a pop in the same cycle frees the slot; otherwise it is dropped.
module nic_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           push,
  input  logic [0:63]    push_data,
  input  logic           pop,
  output logic [0:63]    head,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [0:63]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (PTR_W+1)'(DEPTH));
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cardinal_node_nic.sv
// NIC between a Cardinal CPU (four 64-bit registers) and its ring router; one FIFO per direction.
// Outputs are combinational from FIFO state; router push is refused when full, CPU writes when full drop.
module cardinal_node_nic
  import nic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [0:1]  addr_nic,
  input  logic [0:63] din_nic,
  output logic [0:63] dout_nic,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  logic           w_cpu_rd;
  logic           w_cpu_wr;
  logic           w_in_push;
  logic           w_in_pop;
  logic [0:63]    w_in_head;
  logic           w_in_full;
  logic           w_in_empty;
  logic [PTR_W:0] w_in_count;
  logic           w_out_push;
  logic [0:63]    w_out_head;
  logic           w_out_full;
  logic           w_out_empty;
  logic [PTR_W:0] w_out_count;

  assign w_cpu_rd = nicEn && !nicWrEn;
  assign w_cpu_wr = nicEn && nicWrEn;

  assign net_ri    = !w_in_full;
  assign w_in_push = net_si && net_ri;
  assign w_in_pop  = w_cpu_rd && (addr_nic == NIC_IN_BUF) && !w_in_empty;

  // The FIFO itself decides whether a write while full fits (only if injecting this cycle).
  assign w_out_push = w_cpu_wr && (addr_nic == NIC_OUT_BUF);
  assign net_so     = !w_out_empty && net_ro && (w_out_head[PKT_VC_BIT] == net_polarity);
  assign net_do     = w_out_empty ? 64'h0 : w_out_head;

  nic_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_in_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (w_in_push),
    .push_data (net_di),
    .pop       (w_in_pop),
    .head      (w_in_head),
    .full      (w_in_full),
    .empty     (w_in_empty),
    .count     (w_in_count)
  );

  nic_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_out_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (w_out_push),
    .push_data (din_nic),
    .pop       (net_so),
    .head      (w_out_head),
    .full      (w_out_full),
    .empty     (w_out_empty),
    .count     (w_out_count)
  );

  always_comb begin
    dout_nic = 64'h0;
    if (w_cpu_rd) begin
      case (addr_nic)
        NIC_IN_BUF:   if (!w_in_empty) dout_nic = w_in_head;
        NIC_IN_STAT:  dout_nic = nic_status(!w_in_empty, 7'(w_in_count));
        NIC_OUT_STAT: dout_nic = nic_status(w_out_full, 7'(w_out_count));
        default:      dout_nic = 64'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_node_nic.sv
// Scoreboard bench for cardinal_node_nic: stimulus queues expected CPU read data and router injections,
// a negedge monitor pops and compares whenever a read is active or net_so is high.
module tb_cardinal_node_nic;
  import nic_pkg::*;

  logic        CLK;
  logic        RESET;
  logic [0:1]  addr_nic;
  logic [0:63] din_nic;
  logic [0:63] dout_nic;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:63] exp_rd_q[$];
  string       exp_rd_name[$];
  logic [0:63] exp_inj_q[$];

  cardinal_node_nic #(.DEPTH(2), .PTR_W(1)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .addr_nic     (addr_nic),
    .din_nic      (din_nic),
    .dout_nic     (dout_nic),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Router VC phase flips every cycle, 1 time unit after the edge.
  initial begin
    net_polarity = 1'b0;
    forever begin
      @(posedge CLK);
      #1 net_polarity = ~net_polarity;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every CPU read and every injection is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET && nicEn && !nicWrEn) begin
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_read", 64'h1, 64'h0);
        end else begin
          logic [0:63] e;
          string       nm;
          e  = exp_rd_q.pop_front();
          nm = exp_rd_name.pop_front();
          chk(nm, dout_nic, e);
        end
      end
      if (!RESET && net_so) begin
        if (exp_inj_q.size() == 0) begin
          chk("unexpected_injection", net_do, 64'h0);
        end else begin
          logic [0:63] e;
          e = exp_inj_q.pop_front();
          chk("inj_data", net_do, e);
          chk("inj_polarity", {63'b0, net_polarity}, {63'b0, e[0]});
        end
      end
    end
  end

  task automatic begin_cycle();
    @(posedge CLK);
    #2;
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    net_si  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin_cycle();
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic [0:63] e, input string nm);
    begin_cycle();
    nicEn    = 1'b1;
    nicWrEn  = 1'b0;
    addr_nic = a;
    exp_rd_q.push_back(e);
    exp_rd_name.push_back(nm);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [0:63] d);
    begin_cycle();
    nicEn    = 1'b1;
    nicWrEn  = 1'b1;
    addr_nic = a;
    din_nic  = d;
  endtask

  task automatic rtr_send(input logic [0:63] d);
    begin_cycle();
    net_si = 1'b1;
    net_di = d;
  endtask

  initial begin
    RESET    = 1'b1;
    addr_nic = 2'b00;
    din_nic  = 64'h0;
    nicEn    = 1'b0;
    nicWrEn  = 1'b0;
    net_si   = 1'b0;
    net_di   = 64'h0;
    net_ro   = 1'b0;

    // Reset state
    idle(5);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_net_ri", {63'b0, net_ri}, 64'h1);
    chk("rst_net_so", {63'b0, net_so}, 64'h0);
    chk("rst_net_do", net_do, 64'h0);
    chk("rst_dout_idle", dout_nic, 64'h0);
    cpu_rd(NIC_IN_STAT,  64'h0, "rst_in_stat");
    cpu_rd(NIC_OUT_STAT, 64'h0, "rst_out_stat");
    cpu_rd(NIC_IN_BUF,   64'h0, "rd_empty_in_buf");

    // Inbound single packet, readable the cycle after acceptance
    rtr_send(64'h00000000_DEADBEEF);
    cpu_rd(NIC_IN_STAT, 64'h3, "in_stat_one");
    cpu_rd(NIC_IN_BUF,  64'h00000000_DEADBEEF, "in_buf_deadbeef");
    cpu_rd(NIC_IN_STAT, 64'h0, "in_stat_after_pop");

    // Writes to a non-output address do nothing and read data stays zero
    cpu_wr(NIC_IN_BUF, 64'h12345678_9ABCDEF0);
    @(negedge CLK);
    chk("wr_dout_zero", dout_nic, 64'h0);
    cpu_rd(NIC_IN_STAT, 64'h0, "in_stat_after_bad_wr");

    // Inbound full: extra packet refused
    rtr_send(64'h01000000_000000A1);
    rtr_send(64'h00000000_000000A2);
    begin_cycle();
    @(negedge CLK);
    chk("in_full_net_ri", {63'b0, net_ri}, 64'h0);
    rtr_send(64'h00000000_000000A3);
    cpu_rd(NIC_IN_STAT, 64'h5, "in_stat_full");
    cpu_rd(NIC_IN_BUF,  64'h01000000_000000A1, "in_buf_a1");
    cpu_rd(NIC_IN_BUF,  64'h00000000_000000A2, "in_buf_a2");
    cpu_rd(NIC_IN_BUF,  64'h0, "in_buf_drained");

    // Outbound VC=1 packet waits for polarity 1
    net_ro = 1'b1;
    cpu_wr(NIC_OUT_BUF, 64'h80000000_00000001);
    exp_inj_q.push_back(64'h80000000_00000001);
    idle(4);
    cpu_rd(NIC_OUT_STAT, 64'h0, "out_stat_after_inj");

    // Backpressure: third write dropped, two injections in order
    net_ro = 1'b0;
    cpu_wr(NIC_OUT_BUF, 64'h00000000_000000B1);
    cpu_wr(NIC_OUT_BUF, 64'h80000000_000000B2);
    cpu_wr(NIC_OUT_BUF, 64'h00000000_000000B3);
    exp_inj_q.push_back(64'h00000000_000000B1);
    exp_inj_q.push_back(64'h80000000_000000B2);
    cpu_rd(NIC_OUT_STAT, 64'h5, "out_stat_full");
    begin_cycle();
    net_ro = 1'b1;
    idle(6);
    cpu_rd(NIC_OUT_STAT, 64'h0, "out_stat_drained");

    // Full out-FIFO: write in the same cycle as an injection is accepted
    net_ro = 1'b0;
    cpu_wr(NIC_OUT_BUF, 64'h00000000_000000C1);
    cpu_wr(NIC_OUT_BUF, 64'h80000000_000000C2);
    exp_inj_q.push_back(64'h00000000_000000C1);
    exp_inj_q.push_back(64'h80000000_000000C2);
    exp_inj_q.push_back(64'h00000000_000000C3);
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      if (net_polarity) break;
    end
    cpu_wr(NIC_OUT_BUF, 64'h00000000_000000C3);
    net_ro = 1'b1;
    @(negedge CLK);
    chk("simul_net_so", {63'b0, net_so}, 64'h1);
    begin_cycle();
    net_ro = 1'b0;
    cpu_rd(NIC_OUT_STAT, 64'h5, "simul_out_stat");

    // Reset mid-stream discards everything buffered
    rtr_send(64'h00000000_000000D1);
    cpu_rd(NIC_IN_STAT, 64'h3, "in_stat_before_rst");
    begin_cycle();
    RESET = 1'b1;
    exp_inj_q.delete();
    cpu_rd(NIC_IN_STAT, 64'h0, "in_stat_after_rst");
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst2_net_ri", {63'b0, net_ri}, 64'h1);
    cpu_rd(NIC_OUT_STAT, 64'h0, "out_stat_after_rst");
    net_ro = 1'b1;
    idle(4);

    chk("rd_queue_drained",  64'(exp_rd_q.size()),  64'h0);
    chk("inj_queue_drained", 64'(exp_inj_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cardinal_node_nic.md
# cardinal_node_nic

Network interface controller between one Cardinal CPU's NIC port and its ring router. It buffers packets in both directions in small FIFOs. The CPU sees the block as four memory-mapped 64-bit registers. Router-side transfers use the ring's ready/send handshake and even/odd virtual-channel polarity.

## Interface

Parameters:
- DEPTH, default 2: entries per channel FIFO; power of two, minimum 2.
- PTR_W, default 1: log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high.
- addr_nic  in  [0:1]  register select. 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
- din_nic  in  [0:63]  CPU write data.
- dout_nic  out  [0:63]  CPU read data.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = write, 0 = read; only meaningful when nicEn = 1.
- net_si  in  1  router has a packet for this node.
- net_ri  out  1  NIC can accept a packet from the router.
- net_di  in  [0:63]  packet from the router.
- net_so  out  1  NIC injects a packet this cycle.
- net_ro  in  1  router can accept an injection.
- net_do  out  [0:63]  injected packet.
- net_polarity  in  1  current router VC phase; toggles every cycle.

## Operation

- Packet layout:
  - bit 0: VC.
  - bit 1: direction.
  - bits 8:15: hop count.
  - bits 16:31: source.
  - bits 32:63: payload.
  - The NIC interprets only bit 0.
- Input channel (router → CPU):
  - net_ri = !in_full.
  - When net_si && net_ri, push net_di at the edge.
  - net_si while net_ri = 0 is a router protocol error; the packet is ignored and in-FIFO state is unchanged.
- CPU read of addr 00 (nicEn=1, nicWrEn=0):
  - dout_nic = in-FIFO head.
  - Pops the head at the edge if the FIFO is non-empty.
  - Reading an empty FIFO returns 64'h0 and does not pop.
- Input status, addr 01:
  - dout_nic[63] = in_nonempty.
  - dout_nic[56:62] = in-FIFO occupancy.
  - All other bits 0.
- Output channel (CPU → router):
  - CPU write of addr 10 (nicEn=1, nicWrEn=1) pushes din_nic if the out-FIFO is not full.
  - A write while full is dropped silently.
- Output status, addr 11:
  - dout_nic[63] = out_full.
  - dout_nic[56:62] = out-FIFO occupancy.
- Writes to addr 00, 01 and 11 are ignored.
- When nicEn=0, or on a write access, dout_nic = 64'h0.
- Injection:
  - net_so = out_nonempty && net_ro && (out_head[0] == net_polarity).
  - net_do = out_head while the out-FIFO is non-empty, else 64'h0.
  - Pop at the edge when net_so=1.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle: occupancy unchanged, data order preserved. This holds even when the FIFO is full, because on the output side the pop makes room. The input side does not allow this when full, since net_ri=0.
  - Pointers wrap modulo DEPTH.

## Timing

- Reset values:
  - Both FIFOs empty, pointers and counts 0.
  - net_ri=1, net_so=0, net_do=0, dout_nic=0.
  - FIFO data contents are don't-care.
- RESET asserted mid-transfer discards all buffered packets on the next edge.
- dout_nic, net_ri, net_so and net_do are combinational from registered state plus inputs (addr_nic, nicEn, nicWrEn, net_ro, net_polarity). The CPU samples read data in the same cycle, as with dmem.
- Router → CPU latency: packet accepted at edge N is readable in cycle N+1 (status bit 63 = 1).
- CPU → router latency: write at edge N makes net_so eligible in cycle N+1. Worst case adds one cycle of polarity wait.
- Throughput: one push and one pop per FIFO per cycle.

## Structure

- Shared package nic_pkg holds:
  - Address constants NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11.
  - PKT_VC_BIT=0 and the packet field ranges.
- Sub-module nic_fifo (params DEPTH, PTR_W):
  - Ports: CLK, RESET, push, push_data, pop, head, full, empty, count.
  - Instantiated twice, once per channel.
- Top level holds only address decode, the handshake equations and the output mux.

## Test plan

- Reset: hold RESET 5 cycles → net_ri=1, net_so=0, reads of addr 01 and 11 return 64'h0.
- Inbound: drive net_si=1 with net_di=64'h00000000_DEADBEEF for one cycle.
  - Next cycle, addr 01 reads bit 63=1 and count 1.
  - Read addr 00 → 64'h00000000_DEADBEEF; the following addr 01 read → 0.
- Inbound full: push DEPTH packets with no CPU reads → net_ri=0.
  - An extra net_si packet is not stored.
  - Reads return the first DEPTH packets in order.
- Outbound polarity: write 64'h80000000_00000001 (VC=1) with net_ro=1 and net_polarity toggling.
  - net_so pulses only in a cycle with net_polarity=1; net_do equals the written value.
  - Out-FIFO is empty afterwards.
- Outbound backpressure: net_ro=0, write DEPTH+1 packets → addr 11 bit 63=1, last write dropped.
  - Raise net_ro → exactly DEPTH injections, in order.
- Simultaneous: with the out-FIFO full and injecting, perform a CPU write in the same cycle → write accepted, count stays DEPTH.
  - Assert RESET mid-stream → both FIFOs empty next cycle.
